// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with optional auto-scan (dwell-timed walk, wrap pulse).
// Latency: 1 cycle from select accept (or scan advance) to dout/idx/wrap.
// Backpressure: sel_ready is combinational (rst_n & en & ~mode); selects are refused while disabled or scanning.
//
// Build option: define DECODER_SCAN_EN to build scan mode, the dwell counter and wrap.
// Without it, mode and dwell are ignored, the block is always in direct mode and wrap is tied low.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                enable; 0 blanks dout and wrap at the next edge, idx holds
//   mode              0 = direct (decode accepted sel), 1 = scan (walk outputs)
//   sel_valid/ready   select handshake; sel sampled on accept
//   dwell             scan dwell; each output is active for dwell+1 cycles
//   dout, idx, wrap   registered one-hot output, active index, scan wrap pulse
module decoder_scan #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  sel_valid,
    output logic                  sel_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(1<<SEL_W)-1:0] dout,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int N = 1 << SEL_W;

    logic             accept;
    logic [SEL_W-1:0] idx_next;

`ifdef DECODER_SCAN_EN
    logic [DWELL_W-1:0] cnt;
    logic               advance;

    assign sel_ready = rst_n & en & ~mode;
    // dwell is compared live, so lowering it below cnt forces an advance next edge
    assign advance   = mode & (cnt >= dwell);
`else
    logic unused_scan_inputs;

    assign sel_ready          = rst_n & en;
    assign unused_scan_inputs = ^{mode, dwell};
`endif

    assign accept = sel_valid & sel_ready;

    always_comb begin
        idx_next = idx;
        if (accept) begin
            idx_next = sel;
`ifdef DECODER_SCAN_EN
        end else if (advance) begin
            // natural SEL_W-bit overflow gives the modulo-2^SEL_W wrap
            idx_next = idx + SEL_W'(1);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            dout <= '0;
        end else if (en) begin
            idx  <= idx_next;
            dout <= N'(1) << idx_next;
        end else begin
            dout <= '0;
        end
    end

`ifdef DECODER_SCAN_EN
    // cnt stays at 0 outside scan mode and while disabled, so entering scan
    // or re-enabling always starts a fresh dwell on the current idx
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (en && mode) begin
            cnt  <= advance ? '0 : cnt + DWELL_W'(1);
            wrap <= advance && (idx == SEL_W'(N - 1));
        end else begin
            cnt  <= '0;
            wrap <= 1'b0;
        end
    end
`else
    assign wrap = 1'b0;
`endif

endmodule
